wb_regfile_scoreboard: RTL and testbench



---
 rtl/wb_regfile_scoreboard_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 87 ++++++++
 rtl/wb_regfile_scoreboard.sv | 65 ++++++
 tb/tb_wb_regfile_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared constants, request payload and decode helper for the write-back register file and scoreboard.
package wb_regfile_scoreboard_pkg;

  localparam int unsigned REG_NO_WIDTH       = 4;
  localparam int unsigned NUM_REGS           = 16;
  localparam int unsigned DATA_BIT_WIDTH_DEF = 32;
  localparam int unsigned PEND_CNT_WIDTH_DEF = 2;

  typedef logic [REG_NO_WIDTH-1:0] regNo_t;

  // A qualified request against one architectural register (issue or retire).
  typedef struct packed {
    logic   valid;
    regNo_t regNo;
  } regReq_t;

  function automatic logic [NUM_REGS-1:0] regOneHot(input regReq_t req);
    logic [NUM_REGS-1:0] oneHot;
    oneHot = '0;
    if (req.valid) oneHot[req.regNo] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, RAW/saturation stall and drain indicator.
// Optional same-cycle retire release under WB_BYPASS_EN.
module wb_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int unsigned PEND_CNT_WIDTH = PEND_CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrReg,
  input  logic [REG_NO_WIDTH-1:0] regWriteNo,
  input  logic [REG_NO_WIDTH-1:0] rdRegNo1,
  input  logic [REG_NO_WIDTH-1:0] rdRegNo2,
  input  logic                    rdUse1,
  input  logic                    rdUse2,
  input  logic                    issueValid,
  input  logic                    issueWrReg,
  input  logic [REG_NO_WIDTH-1:0] issueRegNo,
  output logic                    stall,
  output logic                    pendingAny
);

  localparam logic [PEND_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_CNT_WIDTH-1:0] CNT_ONE = PEND_CNT_WIDTH'(1);

  logic [PEND_CNT_WIDTH-1:0] cnt     [NUM_REGS];
  logic [PEND_CNT_WIDTH-1:0] cntNext [NUM_REGS];

  logic          retireHit1;
  logic          retireHit2;
  logic          busy1;
  logic          busy2;
  logic          destFull;
  logic          inc;
  regReq_t       issueReq;
  regReq_t       retireReq;
  logic [NUM_REGS-1:0] incVec;
  logic [NUM_REGS-1:0] decVec;

`ifdef WB_BYPASS_EN
  // The last outstanding write retiring this cycle already satisfies the reader.
  assign retireHit1 = wrReg && (regWriteNo == rdRegNo1) && (cnt[rdRegNo1] == CNT_ONE);
  assign retireHit2 = wrReg && (regWriteNo == rdRegNo2) && (cnt[rdRegNo2] == CNT_ONE);
`else
  assign retireHit1 = 1'b0;
  assign retireHit2 = 1'b0;
`endif

  assign busy1    = rdUse1 && (cnt[rdRegNo1] != '0) && !retireHit1;
  assign busy2    = rdUse2 && (cnt[rdRegNo2] != '0) && !retireHit2;
  assign destFull = issueWrReg && (cnt[issueRegNo] == CNT_MAX);
  assign stall    = issueValid && (busy1 || busy2 || destFull);
  assign inc      = issueValid && !stall && issueWrReg;

  assign issueReq  = '{valid: inc,   regNo: issueRegNo};
  assign retireReq = '{valid: wrReg, regNo: regWriteNo};
  assign incVec    = regOneHot(issueReq);
  assign decVec    = regOneHot(retireReq);

  // Inc and dec on the same register cancel; dec at zero is dropped.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cntNext[r] = cnt[r];
      if (incVec[r] && !decVec[r]) begin
        cntNext[r] = cnt[r] + CNT_ONE;
      end else if (decVec[r] && !incVec[r] && (cnt[r] != '0)) begin
        cntNext[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cntNext[r];
    end
  end

  always_comb begin
    pendingAny = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt[r] != '0) pendingAny = 1'b1;
    end
  end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file (16 x DATA_BIT_WIDTH, two read ports) with pending-write scoreboard.
// Define WB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module wb_regfile_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int unsigned              DATA_BIT_WIDTH  = DATA_BIT_WIDTH_DEF,
  parameter logic [DATA_BIT_WIDTH-1:0] REG_RESET_VALUE = '0,
  parameter int unsigned              PEND_CNT_WIDTH  = PEND_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_BIT_WIDTH-1:0] wrRegData,
  input  logic [REG_NO_WIDTH-1:0]   regWriteNo,
  input  logic                      wrReg,
  input  logic [REG_NO_WIDTH-1:0]   rdRegNo1,
  input  logic [REG_NO_WIDTH-1:0]   rdRegNo2,
  input  logic                      rdUse1,
  input  logic                      rdUse2,
  output logic [DATA_BIT_WIDTH-1:0] rdData1,
  output logic [DATA_BIT_WIDTH-1:0] rdData2,
  input  logic                      issueValid,
  input  logic                      issueWrReg,
  input  logic [REG_NO_WIDTH-1:0]   issueRegNo,
  output logic                      stall,
  output logic                      pendingAny
);

  logic [DATA_BIT_WIDTH-1:0] regs [NUM_REGS];

  // Architectural array; every entry writable, including r0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= REG_RESET_VALUE;
    end else if (wrReg) begin
      regs[regWriteNo] <= wrRegData;
    end
  end

`ifdef WB_BYPASS_EN
  assign rdData1 = (wrReg && (regWriteNo == rdRegNo1)) ? wrRegData : regs[rdRegNo1];
  assign rdData2 = (wrReg && (regWriteNo == rdRegNo2)) ? wrRegData : regs[rdRegNo2];
`else
  assign rdData1 = regs[rdRegNo1];
  assign rdData2 = regs[rdRegNo2];
`endif

  wb_scoreboard #(
    .PEND_CNT_WIDTH(PEND_CNT_WIDTH)
  ) uScoreboard (
    .clk       (clk),
    .reset     (reset),
    .wrReg     (wrReg),
    .regWriteNo(regWriteNo),
    .rdRegNo1  (rdRegNo1),
    .rdRegNo2  (rdRegNo2),
    .rdUse1    (rdUse1),
    .rdUse2    (rdUse2),
    .issueValid(issueValid),
    .issueWrReg(issueWrReg),
    .issueRegNo(issueRegNo),
    .stall     (stall),
    .pendingAny(pendingAny)
  );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues expected output values, a negedge monitor pops and compares.
module tb_wb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [31:0] wrRegData;
  logic [3:0]  regWriteNo;
  logic        wrReg;
  logic [3:0]  rdRegNo1;
  logic [3:0]  rdRegNo2;
  logic        rdUse1;
  logic        rdUse2;
  logic [31:0] rdData1;
  logic [31:0] rdData2;
  logic        issueValid;
  logic        issueWrReg;
  logic [3:0]  issueRegNo;
  logic        stall;
  logic        pendingAny;

  int errors = 0;
  int checks = 0;

  int          selQ [$];
  logic [31:0] expQ [$];
  string       nameQ[$];

  localparam int SEL_RD1  = 0;
  localparam int SEL_RD2  = 1;
  localparam int SEL_STL  = 2;
  localparam int SEL_PEND = 3;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .wrRegData (wrRegData),
    .regWriteNo(regWriteNo),
    .wrReg     (wrReg),
    .rdRegNo1  (rdRegNo1),
    .rdRegNo2  (rdRegNo2),
    .rdUse1    (rdUse1),
    .rdUse2    (rdUse2),
    .rdData1   (rdData1),
    .rdData2   (rdData2),
    .issueValid(issueValid),
    .issueWrReg(issueWrReg),
    .issueRegNo(issueRegNo),
    .stall     (stall),
    .pendingAny(pendingAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    selQ.push_back(sel);
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrReg      = 1'b0;
    issueValid = 1'b0;
    issueWrReg = 1'b0;
    rdUse1     = 1'b0;
    rdUse2     = 1'b0;
  endtask

  task automatic issueW(input logic [3:0] r);
    issueValid = 1'b1;
    issueWrReg = 1'b1;
    issueRegNo = r;
  endtask

  task automatic retire(input logic [3:0] r, input logic [31:0] d);
    wrReg      = 1'b1;
    regWriteNo = r;
    wrRegData  = d;
  endtask

  // Monitor: compare every queued expectation against the live outputs mid-cycle.
  initial begin
    int          sel;
    logic [31:0] exp;
    logic [31:0] act;
    string       name;
    forever begin
      @(negedge clk);
      while (selQ.size() > 0) begin
        sel  = selQ.pop_front();
        exp  = expQ.pop_front();
        name = nameQ.pop_front();
        case (sel)
          SEL_RD1: act = rdData1;
          SEL_RD2: act = rdData2;
          SEL_STL: act = {31'b0, stall};
          default: act = {31'b0, pendingAny};
        endcase
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    wrRegData = '0; regWriteNo = '0; rdRegNo1 = '0; rdRegNo2 = '0; issueRegNo = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Post-reset state
    rdRegNo1 = 4'd0; rdRegNo2 = 4'd15;
    chk(SEL_RD1, 32'h0, "rst_rd1"); chk(SEL_RD2, 32'h0, "rst_rd2");
    chk(SEL_STL, 32'h0, "rst_stall"); chk(SEL_PEND, 32'h0, "rst_pend");
    step();

    // Write r5 then read it
    retire(4'd5, 32'hDEADBEEF); rdRegNo1 = 4'd5;
    chk(SEL_RD1, BYP ? 32'hDEADBEEF : 32'h0, "wr_same_cycle");
    step();
    idle(); chk(SEL_RD1, 32'hDEADBEEF, "wr_next_cycle");
    retire(4'd0, 32'hA5A5A5A5); rdRegNo2 = 4'd0;
    chk(SEL_RD2, BYP ? 32'hA5A5A5A5 : 32'h0, "wr_r0_same");
    step();
    idle(); chk(SEL_RD2, 32'hA5A5A5A5, "wr_r0_next");
    step();

    // Two writers to r9 in flight, then async reset between edges
    issueW(4'd9); chk(SEL_STL, 32'h0, "iss9_a"); step();
    issueW(4'd9); chk(SEL_STL, 32'h0, "iss9_b"); step();
    idle(); chk(SEL_PEND, 32'h1, "r9_pending"); step();
    reset = 1'b1;
    rdRegNo1 = 4'd5; rdRegNo2 = 4'd0;
    issueValid = 1'b1; rdUse2 = 1'b1; rdRegNo2 = 4'd9;
    chk(SEL_RD1, 32'h0, "async_rst_r5");
    chk(SEL_STL, 32'h0, "async_rst_stall");
    chk(SEL_PEND, 32'h0, "async_rst_pend");
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      rdRegNo1 = 4'(2 * i); rdRegNo2 = 4'(2 * i + 1);
      chk(SEL_RD1, 32'h0, "rst_sweep_rd1"); chk(SEL_RD2, 32'h0, "rst_sweep_rd2");
      step();
    end
    reset = 1'b0;
    retire(4'd9, 32'h55); chk(SEL_PEND, 32'h0, "r9_wb_after_rst");
    step();
    idle(); rdRegNo1 = 4'd9; issueValid = 1'b1; rdUse1 = 1'b1;
    chk(SEL_RD1, 32'h55, "r9_data"); chk(SEL_PEND, 32'h0, "r9_no_underflow");
    chk(SEL_STL, 32'h0, "r9_no_stall");
    step();

    // RAW on r3 via port 1
    idle(); issueW(4'd3); chk(SEL_STL, 32'h0, "raw_issue"); step();
    idle(); issueValid = 1'b1; rdUse1 = 1'b1; rdRegNo1 = 4'd3;
    chk(SEL_STL, 32'h1, "raw_stall_1"); step();
    chk(SEL_STL, 32'h1, "raw_stall_2"); step();
    retire(4'd3, 32'h33);
    chk(SEL_STL, BYP ? 32'h0 : 32'h1, "raw_retire_cycle");
    chk(SEL_RD1, BYP ? 32'h33 : 32'h0, "raw_retire_data");
    step();
    wrReg = 1'b0;
    chk(SEL_STL, 32'h0, "raw_released"); chk(SEL_RD1, 32'h33, "raw_data");
    chk(SEL_PEND, 32'h0, "raw_drained");
    step();

    // rdUse gating, then RAW on r6 via port 2
    idle(); issueW(4'd6); step();
    idle(); issueValid = 1'b1; rdRegNo1 = 4'd6; rdRegNo2 = 4'd6;
    chk(SEL_STL, 32'h0, "use_gated"); step();
    rdUse2 = 1'b1; chk(SEL_STL, 32'h1, "raw2_stall"); step();
    retire(4'd6, 32'h66); chk(SEL_STL, BYP ? 32'h0 : 32'h1, "raw2_retire_cycle"); step();
    idle(); chk(SEL_PEND, 32'h0, "raw2_drained"); step();

    // Saturation on r7
    for (int i = 0; i < 3; i++) begin
      issueW(4'd7); chk(SEL_STL, 32'h0, "sat_accept"); step();
    end
    issueW(4'd7); chk(SEL_STL, 32'h1, "sat_full_stall"); chk(SEL_PEND, 32'h1, "sat_pend"); step();
    idle(); retire(4'd7, 32'h71); step();
    retire(4'd7, 32'h72); step();
    retire(4'd7, 32'h73); chk(SEL_PEND, 32'h1, "sat_last_outstanding"); step();
    idle(); chk(SEL_PEND, 32'h0, "sat_drained"); step();

    // Simultaneous issue/retire
    issueW(4'd2); chk(SEL_STL, 32'h0, "sim_issue"); step();
    issueW(4'd2); retire(4'd2, 32'h22); chk(SEL_STL, 32'h0, "sim_same_reg"); step();
    idle(); chk(SEL_PEND, 32'h1, "sim_r2_kept"); step();
    issueW(4'd4); retire(4'd2, 32'h222); chk(SEL_STL, 32'h0, "sim_diff_reg"); step();
    idle(); issueValid = 1'b1; rdUse1 = 1'b1; rdRegNo1 = 4'd2;
    chk(SEL_STL, 32'h0, "sim_r2_zero"); chk(SEL_PEND, 32'h1, "sim_r4_pend"); step();
    rdRegNo1 = 4'd4; chk(SEL_STL, 32'h1, "sim_r4_one"); step();
    idle(); retire(4'd4, 32'h44); step();
    idle(); chk(SEL_PEND, 32'h0, "sim_drained"); step();

    // Drain outstanding expectations with a bound
    for (int i = 0; i < 20 && selQ.size() > 0; i++) @(negedge clk);
    #1;
    if (selQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", selQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
